mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_req_latch.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding and the
// command bundle carried from a request port to the memory port.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIBusy = 2'd1,
    StDBusy = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        wr;
    logic        w;
    logic        hw;
    logic [31:0] adr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_req_latch.sv
// Per-port request capture: a pending flag plus the attributes of the
// accepted request. The flag stays set while the port is being serviced and
// clears on its completion, so a pulse during that window is an overrun.
module mem_bus_arbiter_req_latch
  import mem_bus_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req,
  input  mem_cmd_t cmd,
  input  logic     done,
  output logic     pending_next,
  output mem_cmd_t cmd_next,
  output logic     ovr
);

  logic     pending_q, pending_d;
  mem_cmd_t cmd_q, cmd_d;
  logic     accept;

  // A pulse on the completion cycle of this port is a fresh request.
  always_comb begin
    accept       = req & (~pending_q | done);
    ovr          = req & pending_q & ~done;
    pending_d    = accept | (pending_q & ~done);
    cmd_d        = accept ? cmd : cmd_q;
    pending_next = pending_d;
    cmd_next     = cmd_d;
  end

  // Pending flag and attribute storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction / data) arbiter onto a single memory port with one
// outstanding transaction and round-robin tie-breaking.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  output logic        i_read_valid,
  output logic [31:0] i_read_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic        d_w,
  input  logic        d_hw,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic        m_w,
  output logic        m_hw,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic        m_valid,
  input  logic [31:0] m_rdata,
  output logic        arb_ovr
);

  arb_state_e state_q, state_d;
  mem_cmd_t   i_cmd, d_cmd, i_cmd_next, d_cmd_next, m_cmd_q;
  logic       i_pend_next, d_pend_next, i_ovr, d_ovr;
  logic       done_i, done_d, free, grant_i, grant_d;
  logic       last_d_q, m_req_q, ovr_q;

  // Instruction fetches never write.
  assign i_cmd = '{wr: 1'b0, w: i_read_w, hw: i_read_hw, adr: i_read_adr, wdata: 32'd0};
  assign d_cmd = '{wr: d_wr, w: d_w, hw: d_hw, adr: d_adr, wdata: d_wdata};

  assign done_i = (state_q == StIBusy) & m_valid;
  assign done_d = (state_q == StDBusy) & m_valid;
  assign free   = (state_q == StIdle) | done_i | done_d;

  mem_bus_arbiter_req_latch u_i_latch (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (i_read_req),
    .cmd          (i_cmd),
    .done         (done_i),
    .pending_next (i_pend_next),
    .cmd_next     (i_cmd_next),
    .ovr          (i_ovr)
  );

  mem_bus_arbiter_req_latch u_d_latch (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (d_req),
    .cmd          (d_cmd),
    .done         (done_d),
    .pending_next (d_pend_next),
    .cmd_next     (d_cmd_next),
    .ovr          (d_ovr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Grant decision whenever the bus is free this cycle (idle or completing).
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (free) begin
      if (i_pend_next && d_pend_next) begin
        grant_i = last_d_q;
        grant_d = ~last_d_q;
      end else begin
        grant_i = i_pend_next;
        grant_d = d_pend_next;
      end
      if (grant_d)      state_d = StDBusy;
      else if (grant_i) state_d = StIBusy;
      else              state_d = StIdle;
    end
  end

  // Completion is forwarded combinationally to the owning port only.
  always_comb begin
    i_read_valid = done_i;
    d_valid      = done_d;
    i_read_data  = done_i ? m_rdata : 32'd0;
    d_rdata      = done_d ? m_rdata : 32'd0;
  end

  // Memory command registered at grant and held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_q  <= 1'b0;
      m_cmd_q  <= '0;
      last_d_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      m_req_q <= grant_i | grant_d;
      ovr_q   <= ovr_q | i_ovr | d_ovr;
      if (grant_d) begin
        m_cmd_q  <= d_cmd_next;
        last_d_q <= 1'b1;
      end else if (grant_i) begin
        m_cmd_q  <= i_cmd_next;
        last_d_q <= 1'b0;
      end
    end
  end

  assign m_req   = m_req_q;
  assign m_wr    = m_cmd_q.wr;
  assign m_w     = m_cmd_q.w;
  assign m_hw    = m_cmd_q.hw;
  assign m_adr   = m_cmd_q.adr;
  assign m_wdata = m_cmd_q.wdata;
  assign arb_ovr = ovr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read_req, i_read_w, i_read_hw;
  logic [31:0] i_read_adr;
  logic        i_read_valid;
  logic [31:0] i_read_data;
  logic        d_req, d_wr, d_w, d_hw;
  logic [31:0] d_adr, d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        m_req, m_wr, m_w, m_hw;
  logic [31:0] m_adr, m_wdata;
  logic        m_valid;
  logic [31:0] m_rdata;
  logic        arb_ovr;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read_req   (i_read_req),
    .i_read_w     (i_read_w),
    .i_read_hw    (i_read_hw),
    .i_read_adr   (i_read_adr),
    .i_read_valid (i_read_valid),
    .i_read_data  (i_read_data),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .d_w          (d_w),
    .d_hw         (d_hw),
    .d_adr        (d_adr),
    .d_wdata      (d_wdata),
    .d_valid      (d_valid),
    .d_rdata      (d_rdata),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_w          (m_w),
    .m_hw         (m_hw),
    .m_adr        (m_adr),
    .m_wdata      (m_wdata),
    .m_valid      (m_valid),
    .m_rdata      (m_rdata),
    .arb_ovr      (arb_ovr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus (0 none, 1 instr, 2 data), which ports
  // have an outstanding request, their attributes, and the expected memory
  // command currently presented.
  int          owner;
  bit          pend_i, pend_d, last_was_d, ovr_m;
  bit          ia_w, ia_hw, da_wr, da_w, da_hw;
  logic [31:0] ia_adr, da_adr, da_wdata;
  bit          e_req, e_wr, e_w, e_hw;
  logic [31:0] e_adr, e_wdata;
  bit          grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; pend_i = 0; pend_d = 0; last_was_d = 0; ovr_m = 0;
    ia_w = 0; ia_hw = 0; ia_adr = 0;
    da_wr = 0; da_w = 0; da_hw = 0; da_adr = 0; da_wdata = 0;
    e_req = 0; e_wr = 0; e_w = 0; e_hw = 0; e_adr = 0; e_wdata = 0;
  endtask

  // Advance the model by one clock using the inputs present this cycle.
  task automatic model_step();
    bit done_i, done_d, bus_free;
    int g;
    done_i   = (owner == 1) && m_valid;
    done_d   = (owner == 2) && m_valid;
    bus_free = (owner == 0) || done_i || done_d;
    if (i_read_req) begin
      if (pend_i && !done_i) ovr_m = 1;
      else begin
        pend_i = 1; ia_w = i_read_w; ia_hw = i_read_hw; ia_adr = i_read_adr;
      end
    end else if (done_i) pend_i = 0;
    if (d_req) begin
      if (pend_d && !done_d) ovr_m = 1;
      else begin
        pend_d = 1; da_wr = d_wr; da_w = d_w; da_hw = d_hw;
        da_adr = d_adr; da_wdata = d_wdata;
      end
    end else if (done_d) pend_d = 0;
    e_req = 0;
    if (bus_free) begin
      g = 0;
      if (pend_i && pend_d) g = last_was_d ? 1 : 2;
      else if (pend_d)      g = 2;
      else if (pend_i)      g = 1;
      owner = g;
      if (g == 1) begin
        e_req = 1; e_wr = 0; e_w = ia_w; e_hw = ia_hw; e_adr = ia_adr; e_wdata = 0;
        last_was_d = 0;
      end else if (g == 2) begin
        e_req = 1; e_wr = da_wr; e_w = da_w; e_hw = da_hw; e_adr = da_adr;
        e_wdata = da_wdata; last_was_d = 1;
      end
    end
  endtask

  // One clock: compare every output mid-cycle, then step the model.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) model_reset();
    chk("m_req", m_req, e_req);
    chk("m_wr", m_wr, e_wr);
    chk("m_w", m_w, e_w);
    chk("m_hw", m_hw, e_hw);
    chk("m_adr", m_adr, e_adr);
    chk("m_wdata", m_wdata, e_wdata);
    chk("arb_ovr", arb_ovr, ovr_m);
    chk("i_read_valid", i_read_valid, (owner == 1) && m_valid);
    chk("i_read_data", i_read_data, ((owner == 1) && m_valid) ? m_rdata : 32'd0);
    chk("d_valid", d_valid, (owner == 2) && m_valid);
    chk("d_rdata", d_rdata, ((owner == 2) && m_valid) ? m_rdata : 32'd0);
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read_req = 0; i_read_w = 0; i_read_hw = 0; i_read_adr = 0;
    d_req = 0; d_wr = 0; d_w = 0; d_hw = 0; d_adr = 0; d_wdata = 0;
    m_valid = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    model_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_adr", m_adr, 32'd0);
    chk("rst_arb_ovr", arb_ovr, 1'b0);
    @(posedge clk); #1;
    do_reset();

    // Single instruction fetch with 3-cycle memory latency.
    i_read_req = 1; i_read_w = 1; i_read_adr = 32'h0000_0100;
    tick();
    clear_inputs();
    chk("fetch_m_req", m_req, 1'b1);
    chk("fetch_m_adr", m_adr, 32'h100);
    chk("fetch_m_wr", m_wr, 1'b0);
    tick(); tick(); tick();
    m_valid = 1; m_rdata = 32'h0000_0013;
    #1;
    chk("fetch_valid", i_read_valid, 1'b1);
    chk("fetch_data", i_read_data, 32'h13);
    tick();
    clear_inputs();
    #1;
    chk("fetch_valid_off", i_read_valid, 1'b0);
    chk("fetch_data_off", i_read_data, 32'h0);

    // Simultaneous requests after reset: data first, then instruction.
    do_reset();
    i_read_req = 1; i_read_adr = 32'h200;
    d_req = 1; d_wr = 1; d_w = 1; d_adr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    tick();
    clear_inputs();
    chk("tie_m_wr", m_wr, 1'b1);
    chk("tie_m_adr", m_adr, 32'h2000);
    chk("tie_m_wdata", m_wdata, 32'hDEAD_BEEF);
    tick();
    m_valid = 1;
    tick();
    clear_inputs();
    chk("tie_i_m_req", m_req, 1'b1);
    chk("tie_i_m_adr", m_adr, 32'h200);
    chk("tie_i_m_wr", m_wr, 1'b0);
    m_valid = 1;
    tick();
    clear_inputs();

    // Both ports re-request at every completion: grants must alternate.
    do_reset();
    i_read_req = 1; i_read_adr = 32'h300;
    d_req = 1; d_adr = 32'h3000;
    tick();
    clear_inputs();
    for (int g = 0; g < 6; g++) begin
      grants.push_back(m_req && (m_adr == 32'h3000));
      tick();
      m_valid = 1;
      if (owner == 1) begin
        i_read_req = 1; i_read_adr = 32'h300;
      end else begin
        d_req = 1; d_adr = 32'h3000;
      end
      tick();
      clear_inputs();
    end
    for (int k = 0; k < 6; k++) chk("alt_grant_is_d", grants[k], (k % 2) == 0);
    m_valid = 1;
    tick();
    clear_inputs();

    // Overrun: second fetch while the first is still outstanding.
    do_reset();
    i_read_req = 1; i_read_adr = 32'h100;
    tick();
    i_read_adr = 32'h104;
    tick();
    clear_inputs();
    chk("ovr_m_adr", m_adr, 32'h100);
    chk("ovr_flag", arb_ovr, 1'b1);
    m_valid = 1; m_rdata = 32'h55;
    #1;
    chk("ovr_valid_once", i_read_valid, 1'b1);
    tick();
    #1;
    chk("ovr_no_second_valid", i_read_valid, 1'b0);
    tick();
    clear_inputs();
    chk("ovr_no_regrant", m_req, 1'b0);
    chk("ovr_sticky", arb_ovr, 1'b1);

    // Reset while a data access is outstanding, then a late completion.
    do_reset();
    d_req = 1; d_adr = 32'h40; d_w = 1;
    tick();
    clear_inputs();
    tick();
    rst_n = 0;
    #1;
    chk("midrst_m_adr", m_adr, 32'h0);
    chk("midrst_m_w", m_w, 1'b0);
    tick();
    rst_n = 1;
    tick();
    m_valid = 1; m_rdata = 32'h77;
    #1;
    chk("late_d_valid", d_valid, 1'b0);
    chk("late_d_rdata", d_rdata, 32'h0);
    tick();
    clear_inputs();
    chk("late_m_req", m_req, 1'b0);

    // Stray completion while idle.
    m_valid = 1; m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_i_valid", i_read_valid, 1'b0);
    chk("idle_d_valid", d_valid, 1'b0);
    tick();
    clear_inputs();

    // Randomized traffic, including stray completions and overruns.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      i_read_req = ($urandom_range(0, 3) == 0);
      i_read_w   = 1'($urandom);
      i_read_hw  = 1'($urandom);
      i_read_adr = $urandom;
      d_req      = ($urandom_range(0, 3) == 0);
      d_wr       = 1'($urandom);
      d_w        = 1'($urandom);
      d_hw       = 1'($urandom);
      d_adr      = $urandom;
      d_wdata    = $urandom;
      m_valid    = ($urandom_range(0, 2) == 0);
      m_rdata    = $urandom;
      tick();
    end
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
